// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared constants for the gate truth-table self-test.
// Contents: FSM state encodings, response bit positions, the golden
// response table and the legal SETTLE_CYCLES range.
package gate_bist_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef logic [1:0] state_t;

    // Bit positions inside the 7-bit gate response bundle
    localparam int unsigned RESP_AND  = 0;
    localparam int unsigned RESP_OR   = 1;
    localparam int unsigned RESP_NAND = 2;
    localparam int unsigned RESP_NOR  = 3;
    localparam int unsigned RESP_NOTB = 4;
    localparam int unsigned RESP_XOR  = 5;
    localparam int unsigned RESP_XNOR = 6;

    localparam int unsigned RESP_W = 7;

    // Legal range of the settle delay (counter is 4 bits wide)
    localparam int unsigned SETTLE_MIN = 1;
    localparam int unsigned SETTLE_MAX = 15;

    // Expected gate outputs indexed by vector {a,b}
    localparam logic [RESP_W-1:0] GOLDEN [0:3] = '{7'h5C, 7'h26, 7'h36, 7'h43};

    // Golden response lookup for one input vector
    function automatic logic [RESP_W-1:0] golden_resp(input logic [1:0] vec);
        return GOLDEN[vec];
    endfunction

endpackage

// File: rtl/gate_bist_golden.sv
// gate_bist_golden: combinational map from input vector {a,b} to the
// expected 7-bit gate response.
module gate_bist_golden
    import gate_bist_pkg::*;
(
    input  logic [1:0]        i_vec,
    output logic [RESP_W-1:0] o_resp
);

    // Table lookup of the expected response for the current vector
    always_comb begin
        o_resp = golden_resp(i_vec);
    end

endmodule

// File: rtl/gate_bist.sv
// gate_bist: truth-table self-test sequencer for the two-input gate block.
// Walks {a,b} through 00,01,10,11, holds each vector SETTLE_CYCLES cycles,
// samples the gate response for one cycle and records per-vector mismatches.
// Optional build macro: GATE_BIST_CAPTURE_EN -- when defined, the index and
// response of the first failing vector in a run are captured; otherwise the
// first_fail outputs are tied to zero and no capture registers exist.
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2   // legal range 1..15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [RESP_W-1:0] i_resp,
    output logic              o_stim_a,
    output logic              o_stim_b,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [3:0]        o_fail_vec,
    output logic [1:0]        o_first_fail_idx,
    output logic [RESP_W-1:0] o_first_fail_rsp
);

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t            r_state;
    logic [1:0]        r_vec;
    logic [3:0]        r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [3:0]        r_fail_vec;

    logic [RESP_W-1:0] w_golden;
    logic              w_mismatch;
    logic [3:0]        w_fail_next;

    gate_bist_golden u_golden (
        .i_vec  (r_vec),
        .o_resp (w_golden)
    );

    // Compare the sampled response and form the updated fail vector
    always_comb begin
        w_mismatch         = (i_resp != w_golden);
        w_fail_next        = r_fail_vec;
        w_fail_next[r_vec] = w_mismatch;
    end

    // Sequencer FSM: vector stepping, settle counting, result recording
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_vec      <= 2'd0;
            r_cnt      <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail_vec <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state    <= ST_SETTLE;
                        r_vec      <= 2'd0;
                        r_cnt      <= 4'd0;
                        r_fail_vec <= 4'd0;
                        r_pass     <= 1'b0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SAMPLE: begin
                    r_fail_vec <= w_fail_next;
                    if (r_vec == 2'd3) begin
                        // Last vector: pass is judged on the fully updated vector
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= (w_fail_next == 4'd0);
                    end else begin
                        r_vec   <= r_vec + 2'd1;
                        r_cnt   <= 4'd0;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GATE_BIST_CAPTURE_EN
    logic              r_ff_valid;
    logic [1:0]        r_ff_idx;
    logic [RESP_W-1:0] r_ff_rsp;

    // Capture the first mismatching vector of a run; later ones are ignored
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ff_valid <= 1'b0;
            r_ff_idx   <= 2'd0;
            r_ff_rsp   <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_ff_valid <= 1'b0;
            r_ff_idx   <= 2'd0;
            r_ff_rsp   <= '0;
        end else if ((r_state == ST_SAMPLE) && w_mismatch && !r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_idx   <= r_vec;
            r_ff_rsp   <= i_resp;
        end else begin
            r_ff_valid <= r_ff_valid;
        end
    end

    assign o_first_fail_idx = r_ff_idx;
    assign o_first_fail_rsp = r_ff_rsp;
`else
    assign o_first_fail_idx = 2'd0;
    assign o_first_fail_rsp = '0;
`endif

    // The vector register drives the gate inputs directly, so stim is registered
    assign o_stim_a   = r_vec[1];
    assign o_stim_b   = r_vec[0];
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_pass     = r_pass;
    assign o_fail_vec = r_fail_vec;

endmodule
